// File: rtl/core_pkg.sv
// Shared opcode constants, MUL encoding and sequencer state type for the
// hazard/multiplier control slice.
package core_pkg;

    localparam logic [6:0] ALU_R     = 7'b0110011;
    localparam logic [6:0] ALU_I     = 7'b0010011;
    localparam logic [6:0] BRANCH_EQ = 7'b1100011;
    localparam logic [6:0] JUMP      = 7'b1101111;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;

    localparam logic [6:0] MUL_FUNCT7 = 7'b0000001;
    localparam logic [2:0] MUL_FUNCT3 = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == ALU_R) || (op == ALU_I) || (op == BRANCH_EQ) ||
               (op == LOAD)  || (op == STORE);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == ALU_R) || (op == BRANCH_EQ) || (op == STORE);
    endfunction

endpackage

// File: rtl/mul_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard/multiplier controller; master is the
// datapath, slave is the controller.
interface mul_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             enable;
    logic [6:0]       id_opcode;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_is_mul;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             id_ex_bubble;
    logic             ex_mem_bubble;
    logic             mul_start;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output enable, id_opcode, id_rs1, id_rs2, ex_mem_read, ex_rd, ex_is_mul,
        input  pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble,
               mul_start, mul_busy, stall_cnt
    );

    modport slave (
        input  enable, id_opcode, id_rs1, id_rs2, ex_mem_read, ex_rd, ex_is_mul,
        output pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble,
               mul_start, mul_busy, stall_cnt
    );
endinterface

// File: rtl/mul_hazard_ctrl_hazard_detect.sv
// Combinational load-use detection: a LOAD in EX whose destination is a
// source actually read by the instruction in ID.
module hazard_detect
    import core_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    output logic       lu_o
);

    logic hit_rs1;
    logic hit_rs2;

    assign hit_rs1 = uses_rs1(opcode_i) && (ex_rd_i == rs1_i);
    assign hit_rs2 = uses_rs2(opcode_i) && (ex_rd_i == rs2_i);

    // x0 is never a real producer, so a LOAD to x0 cannot create a hazard.
    assign lu_o = ex_mem_read_i && (ex_rd_i != 5'd0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/mul_hazard_ctrl.sv
// Load-use stall and fixed-latency multiplier sequencer: drives pipeline
// write-enables, bubbles, multiplier start and a saturating stall counter.
module mul_hazard_ctrl
    import core_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                arst_n,
    mul_hazard_ctrl_if.slave    bus
);

    localparam logic [3:0] CNT_INIT = 4'((MUL_LATENCY > 2) ? (MUL_LATENCY - 3) : 0);

    mul_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             run_q;

    logic lu;
    logic advance;
    logic mul_trig;
    logic pc_write, if_id_write, id_ex_write;
    logic id_ex_bubble, ex_mem_bubble, mul_start, mul_busy;

    hazard_detect u_hazard_detect (
        .opcode_i      (bus.id_opcode),
        .rs1_i         (bus.id_rs1),
        .rs2_i         (bus.id_rs2),
        .ex_mem_read_i (bus.ex_mem_read),
        .ex_rd_i       (bus.ex_rd),
        .lu_o          (lu)
    );

    assign advance  = run_q && bus.enable;
    assign mul_trig = (state_q == ST_IDLE) && bus.ex_is_mul;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            run_q   <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (advance) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ex_is_mul) begin
                        if (MUL_LATENCY > 2) begin
                            state_d = ST_BUSY;
                            cnt_d   = CNT_INIT;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == 4'd0) state_d = ST_DONE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // MUL freeze outranks load-use; DONE ignores ex_is_mul (same instruction).
    always_comb begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mul_start     = 1'b0;
        mul_busy      = 1'b0;
        if (run_q) begin
            if (!bus.enable) begin
                mul_busy = (state_q != ST_IDLE);
            end else if (mul_trig || (state_q == ST_BUSY)) begin
                mul_start     = mul_trig;
                mul_busy      = 1'b1;
                ex_mem_bubble = 1'b1;
            end else begin
                mul_busy = (state_q == ST_DONE);
                if (lu) begin
                    id_ex_write  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    id_ex_write = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (advance && !pc_write && (stall_q != '1))
            stall_d = stall_q + CNT_W'(1);
    end

    assign bus.pc_write      = pc_write;
    assign bus.if_id_write   = if_id_write;
    assign bus.id_ex_write   = id_ex_write;
    assign bus.id_ex_bubble  = id_ex_bubble;
    assign bus.ex_mem_bubble = ex_mem_bubble;
    assign bus.mul_start     = mul_start;
    assign bus.mul_busy      = mul_busy;
    assign bus.stall_cnt     = stall_q;

endmodule

// File: tb/tb_mul_hazard_ctrl.sv
// Bench for mul_hazard_ctrl: three instances (latency 3, 2, 8; the latency-2 one
// with a 4-bit stall counter) share stimulus and are compared to a cycle model.
module tb_mul_hazard_ctrl;
    import core_pkg::*;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    mul_hazard_ctrl_if #(.CNT_W(32)) bus3 ();
    mul_hazard_ctrl_if #(.CNT_W(4))  bus2 ();
    mul_hazard_ctrl_if #(.CNT_W(32)) bus8 ();

    mul_hazard_ctrl #(.MUL_LATENCY(3), .CNT_W(32)) u_l3 (.clk(clk), .arst_n(arst_n), .bus(bus3));
    mul_hazard_ctrl #(.MUL_LATENCY(2), .CNT_W(4))  u_l2 (.clk(clk), .arst_n(arst_n), .bus(bus2));
    mul_hazard_ctrl #(.MUL_LATENCY(8), .CNT_W(32)) u_l8 (.clk(clk), .arst_n(arst_n), .bus(bus8));

    typedef struct packed {
        logic        pc;
        logic        ifid;
        logic        idex;
        logic        idb;
        logic        exb;
        logic        start;
        logic        busy;
        logic [31:0] sc;
    } obs_t;

    int checks   = 0;
    int failures = 0;

    logic       en_s;
    logic [6:0] op_s;
    logic [4:0] rs1_s, rs2_s, rd_s;
    logic       mr_s, mul_s;

    // Model: m_k is the EX cycle number (1..L) of the MUL in flight, 0 if none.
    bit              m_run;
    int              m_k[3];
    longint unsigned m_stall[3];
    int              e_cur[3];
    obs_t            e_obs[3];

    function automatic int lat_of(input int i);
        return (i == 0) ? 3 : (i == 1) ? 2 : 8;
    endfunction

    function automatic longint unsigned sat_of(input int i);
        return (i == 1) ? 64'd15 : 64'hFFFF_FFFF;
    endfunction

    function automatic obs_t get_obs(input int i);
        obs_t o;
        case (i)
            0: o = '{bus3.pc_write, bus3.if_id_write, bus3.id_ex_write, bus3.id_ex_bubble,
                     bus3.ex_mem_bubble, bus3.mul_start, bus3.mul_busy, bus3.stall_cnt};
            1: o = '{bus2.pc_write, bus2.if_id_write, bus2.id_ex_write, bus2.id_ex_bubble,
                     bus2.ex_mem_bubble, bus2.mul_start, bus2.mul_busy, {28'd0, bus2.stall_cnt}};
            default: o = '{bus8.pc_write, bus8.if_id_write, bus8.id_ex_write, bus8.id_ex_bubble,
                     bus8.ex_mem_bubble, bus8.mul_start, bus8.mul_busy, bus8.stall_cnt};
        endcase
        return o;
    endfunction

    function automatic bit model_lu();
        bit r1, r2;
        r1 = (op_s inside {7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011, 7'b0100011});
        r2 = (op_s inside {7'b0110011, 7'b1100011, 7'b0100011});
        return mr_s && (rd_s != 0) && ((r1 && rd_s == rs1_s) || (r2 && rd_s == rs2_s));
    endfunction

    task automatic drive(input logic en, input logic [6:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic mr, input logic [4:0] rd,
                         input logic mul);
        en_s = en; op_s = op; rs1_s = r1; rs2_s = r2; mr_s = mr; rd_s = rd; mul_s = mul;
        bus3.enable = en; bus3.id_opcode = op; bus3.id_rs1 = r1; bus3.id_rs2 = r2;
        bus3.ex_mem_read = mr; bus3.ex_rd = rd; bus3.ex_is_mul = mul;
        bus2.enable = en; bus2.id_opcode = op; bus2.id_rs1 = r1; bus2.id_rs2 = r2;
        bus2.ex_mem_read = mr; bus2.ex_rd = rd; bus2.ex_is_mul = mul;
        bus8.enable = en; bus8.id_opcode = op; bus8.id_rs1 = r1; bus8.id_rs2 = r2;
        bus8.ex_mem_read = mr; bus8.ex_rd = rd; bus8.ex_is_mul = mul;
    endtask

    task automatic nop();
        drive(1'b1, ALU_R, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0);
    endtask

    task automatic compute_exp();
        for (int i = 0; i < 3; i++) begin
            int L;
            L = lat_of(i);
            e_obs[i] = '0;
            e_cur[i] = 0;
            if (m_run) begin
                if (!en_s) begin
                    e_obs[i].busy = (m_k[i] != 0);
                end else begin
                    e_cur[i] = (m_k[i] == 0 && mul_s) ? 1 : m_k[i];
                    if (e_cur[i] != 0 && e_cur[i] < L) begin
                        e_obs[i].start = (m_k[i] == 0);
                        e_obs[i].busy  = 1'b1;
                        e_obs[i].exb   = 1'b1;
                    end else begin
                        e_obs[i].busy = (e_cur[i] == L);
                        if (model_lu()) begin
                            e_obs[i].idex = 1'b1;
                            e_obs[i].idb  = 1'b1;
                        end else begin
                            e_obs[i].pc   = 1'b1;
                            e_obs[i].ifid = 1'b1;
                            e_obs[i].idex = 1'b1;
                        end
                    end
                end
            end
            e_obs[i].sc = 32'(m_stall[i]);
        end
    endtask

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s L=%0d t=%0t got=%0h exp=%0h", tag, lat_of(i), $time, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        obs_t o;
        compute_exp();
        for (int i = 0; i < 3; i++) begin
            o = get_obs(i);
            chk({tag, ".pc_write"},      i, 32'(o.pc),    32'(e_obs[i].pc));
            chk({tag, ".if_id_write"},   i, 32'(o.ifid),  32'(e_obs[i].ifid));
            chk({tag, ".id_ex_write"},   i, 32'(o.idex),  32'(e_obs[i].idex));
            chk({tag, ".id_ex_bubble"},  i, 32'(o.idb),   32'(e_obs[i].idb));
            chk({tag, ".ex_mem_bubble"}, i, 32'(o.exb),   32'(e_obs[i].exb));
            chk({tag, ".mul_start"},     i, 32'(o.start), 32'(e_obs[i].start));
            chk({tag, ".mul_busy"},      i, 32'(o.busy),  32'(e_obs[i].busy));
            chk({tag, ".stall_cnt"},     i, o.sc,         e_obs[i].sc);
        end
    endtask

    task automatic model_tick();
        if (arst_n) begin
            if (m_run && en_s) begin
                for (int i = 0; i < 3; i++) begin
                    if (e_cur[i] != 0 && e_cur[i] < lat_of(i)) m_k[i] = e_cur[i] + 1;
                    else                                         m_k[i] = 0;
                    if (!e_obs[i].pc && m_stall[i] < sat_of(i)) m_stall[i]++;
                end
            end
            m_run = 1'b1;
        end
    endtask

    task automatic step(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        #1;
        model_tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        m_run  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_k[i]     = 0;
            m_stall[i] = 0;
        end
        #1;
        check_all("reset");
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        logic [4:0] regs[4];
        logic [6:0] op;
        regs = '{5'd0, 5'd5, 5'd6, 5'd7};
        case ($urandom_range(0, 6))
            0: op = ALU_R;
            1: op = ALU_I;
            2: op = BRANCH_EQ;
            3: op = JUMP;
            4: op = LOAD;
            5: op = STORE;
            default: op = 7'h7f;
        endcase
        drive($urandom_range(0, 9) != 0, op, regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
              1'($urandom_range(0, 1)), regs[$urandom_range(0, 2)], $urandom_range(0, 4) == 0);
    endtask

    initial begin
        arst_n = 1'b0;
        nop();
        @(negedge clk);
        do_reset();

        step("first_cycle");
        for (int c = 0; c < 3; c++) step("idle_nop");

        // ADD x6,x5,x1 behind LOAD x5, then the bubble reaches EX
        drive(1'b1, ALU_R, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0); step("lu_add");
        drive(1'b1, ALU_R, 5'd5, 5'd1, 1'b0, 5'd0, 1'b0); step("lu_release");

        drive(1'b1, ALU_R, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0); step("lu_x0");
        drive(1'b1, ALU_I, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0); step("lu_alui_rs2");
        drive(1'b1, JUMP,  5'd5, 5'd5, 1'b1, 5'd5, 1'b0); step("lu_jump_rs1");
        drive(1'b1, STORE, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0); step("lu_store_rs2");
        drive(1'b1, BRANCH_EQ, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0); step("lu_branch_rs2");
        drive(1'b1, 7'h7f, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0); step("lu_unknown");

        // MUL held in EX long enough to cover every latency and back-to-back retrigger
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, ALU_R, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1); step("mul_hold");
        end
        for (int c = 0; c < 9; c++) begin
            nop(); step("mul_drain");
        end

        // Pipeline disabled mid-sequence: state and stall count must hold
        drive(1'b1, ALU_R, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1); step("en_mul");
        nop(); step("en_busy");
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, ALU_R, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1); step("en_low");
        end
        for (int c = 0; c < 8; c++) begin
            nop(); step("en_resume");
        end

        for (int c = 0; c < 500; c++) begin
            rand_inputs(); step("rand_a");
        end

        // Asynchronous reset while the latency-8 instance is in BUSY
        nop(); step("pre_rst");
        drive(1'b1, ALU_R, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1); step("rst_mul");
        nop(); step("rst_busy");
        nop(); step("rst_busy");
        do_reset();
        step("rst_first");
        step("rst_after");

        for (int c = 0; c < 150; c++) begin
            rand_inputs(); step("rand_b");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_hazard_ctrl.md
# mul_hazard_ctrl

Pipeline hazard and multi-cycle multiplier sequencer for the 5-stage RISC-V core. It sits beside the main control unit and drives the PC, IF/ID and ID/EX write-enables, bubble injection and the start strobe of the fixed-latency multiplier in EX. It resolves load-use hazards with a one-cycle stall. It freezes the front of the pipeline while a MUL occupies EX, and it counts stall cycles for performance monitoring.

## Interface
- MUL_LATENCY, 3: multiplier latency in cycles from start to result valid; legal range 2..8.
- CNT_W, 32: width of the stall counter.

- clk  in  1  core clock, all state rising-edge.
- arst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- enable  in  1  global pipeline enable; low freezes everything.
- id_opcode  in  7  opcode of instruction in ID.
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID.
- ex_mem_read  in  1  ID/EX mem_read (LOAD in EX).
- ex_rd  in  5  destination register of instruction in EX.
- ex_is_mul  in  1  instruction in EX is R-type with funct7=0000001, funct3=000.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_write  out  1  ID/EX register enable.
- id_ex_bubble  out  1  zero ID/EX control fields on this edge.
- ex_mem_bubble  out  1  zero EX/MEM control fields on this edge.
- mul_start  out  1  one-cycle multiplier start pulse.
- mul_busy  out  1  multiplier sequence in progress.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- FSM states: IDLE, BUSY, DONE. A run flop clears on reset and sets on the first clk edge after arst_n deasserts. All outputs are forced inactive while run=0.
- Source usage by id_opcode:
  - rs1 used for ALU_R, ALU_I, BRANCH_EQ, LOAD, STORE.
  - rs2 used for ALU_R, BRANCH_EQ, STORE.
  - JUMP and unknown opcodes use neither.
- Load-use hazard (lu) = ex_mem_read & ex_rd!=0 & ((rs1 used & ex_rd==id_rs1) | (rs2 used & ex_rd==id_rs2)).
- MUL trigger = state IDLE & ex_is_mul.
- IDLE with MUL trigger:
  - Outputs: mul_start=1, mul_busy=1, pc_write=if_id_write=id_ex_write=0, ex_mem_bubble=1.
  - Next state is BUSY with cnt=MUL_LATENCY-3 if MUL_LATENCY>2, else DONE.
- BUSY:
  - Same freeze as above, except mul_start=0.
  - cnt decrements each cycle; at cnt==0 next state is DONE.
- DONE:
  - Result valid, so there is no freeze: writes=1, ex_mem_bubble=0, mul_busy=1.
  - ex_is_mul is ignored, since it is the same instruction.
  - Next state is IDLE.
- IDLE/DONE with lu: pc_write=if_id_write=0, id_ex_write=1, id_ex_bubble=1, for one cycle only.
- Otherwise all writes=1 and bubbles=0.
- Priority: MUL freeze > lu. During a MUL freeze id_ex_bubble=0.
- enable=0:
  - FSM, cnt and stall_cnt hold.
  - All writes=0, bubbles=0, mul_start=0; mul_busy reflects state.
- stall_cnt increments when run & enable & pc_write==0, and saturates at all-ones.

## Timing
- Reset values: state IDLE, cnt 0, run 0, stall_cnt 0. All outputs 0 until run=1.
- lu stall: exactly 1 cycle. The dependent instruction stays in ID and reaches EX on the following edge.
- MUL occupies EX for MUL_LATENCY cycles. Front end is frozen for MUL_LATENCY-1 cycles.
- mul_start is high only in the first EX cycle. A back-to-back MUL entering EX the cycle after DONE retriggers from IDLE.
- Reset mid-sequence: returns to IDLE immediately and asynchronously. The partially issued MUL is discarded.

## Structure
- Shared package core_pkg holds:
  - opcode constants ALU_R, ALU_I, BRANCH_EQ, JUMP, LOAD, STORE;
  - MUL funct7/funct3 constants;
  - the FSM state typedef.
- One sub-module, hazard_detect: the combinational lu detection and source-usage decode. The FSM, counters and output muxing live in the top.

## Test plan
- Reset release, enable=1, no hazards:
  - All outputs 0 in the first cycle.
  - From the next cycle: writes=1, bubbles=0, stall_cnt=0.
- LOAD x5 in EX, ADD x6,x5,x1 in ID:
  - One cycle with pc_write=0, if_id_write=0, id_ex_bubble=1.
  - stall_cnt=1.
- Load-use filtering, each case giving no stall:
  - LOAD x0 in EX, ADD using x0 in ID.
  - LOAD x5 in EX, ALU_I whose rs2 field=5.
  - LOAD x5 in EX, JUMP whose rs1 field=5.
- MUL in EX, MUL_LATENCY=3:
  - mul_start 1 cycle.
  - Freeze plus ex_mem_bubble for 2 cycles, then release in DONE.
  - stall_cnt +=2.
  - Repeat with MUL_LATENCY=2 (1-cycle freeze) and 8 (7-cycle freeze).
- Back-to-back MULs: two mul_start pulses separated by MUL_LATENCY cycles; no missed or extra trigger.
- Mid-sequence events:
  - enable=0 during BUSY holds state and stall_cnt.
  - arst_n pulse during BUSY returns to IDLE with all outputs 0.
  - Force stall_cnt near all-ones and confirm saturation.
